// File: rtl/gps_uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gps_uart_pkg : shared types and helpers for the GPS UART receiver. Rev 1.0
// ---------------------------------------------------------------------------
package gps_uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_t;

  localparam int OVS = 16;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud * (OVS / 2)) / (baud * OVS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// byte_fifo : synchronous show-ahead FIFO with push/pop and occupancy. Rev 1.0
// ---------------------------------------------------------------------------
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_depth_check
    $error("byte_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign count    = count_q;
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/gps_uart_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gps_uart_rx : 16x-oversampled 8N1 UART receiver feeding a byte FIFO. Rev 1.0
// ---------------------------------------------------------------------------
module gps_uart_rx
  import gps_uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic                          rxd,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun_err
);

  localparam int DIV    = calc_div(CLK_HZ, BAUD);
  localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIDX_W = $clog2(DATA_BITS + 1);

  if (DIV < 1) begin : g_div_check
    $error("gps_uart_rx: CLK_HZ too low for BAUD at 16x oversampling");
  end

  rx_state_t            state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [3:0]           osc_q, osc_d;
  logic [BIDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 rxd_s, tick, byte_done;
  logic                 fifo_full, fifo_empty;

  assign sync_d = {sync_q[0], rxd};
  assign rxd_s  = sync_q[1];
  assign tick   = (tick_cnt_q == TICK_W'(DIV - 1));

  always_comb begin
    state_d     = state_q;
    osc_d       = osc_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    byte_done   = 1'b0;
    frame_err_d = 1'b0;

    // Held at zero in IDLE so the first tick is phase-locked to the start edge.
    if (state_q == IDLE || tick) tick_cnt_d = '0;
    else                         tick_cnt_d = tick_cnt_q + TICK_W'(1);

    case (state_q)
      IDLE: begin
        if (!rxd_s) begin
          state_d = START;
          osc_d   = '0;
        end
      end
      START: begin
        if (tick) begin
          if (osc_q == 4'(OVS / 2 - 1)) begin
            osc_d     = '0;
            bit_idx_d = '0;
            state_d   = rxd_s ? IDLE : DATA;
          end else begin
            osc_d = osc_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          osc_d = osc_q + 4'd1;
          if (osc_q == 4'(OVS - 1)) begin
            shift_d   = {rxd_s, shift_q[DATA_BITS-1:1]};
            bit_idx_d = bit_idx_q + BIDX_W'(1);
            if (bit_idx_q == BIDX_W'(DATA_BITS - 1)) state_d = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          osc_d = osc_q + 4'd1;
          if (osc_q == 4'(OVS - 1)) begin
            if (rxd_s) begin
              byte_done = 1'b1;
              state_d   = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = WAIT_IDLE;
            end
          end
        end
      end
      WAIT_IDLE: begin
        if (rxd_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A full FIFO with a pop this cycle still accepts the byte.
  assign overrun_d = byte_done && fifo_full && !rd_ready;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= IDLE;
      sync_q      <= 2'b11;
      tick_cnt_q  <= '0;
      osc_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      tick_cnt_q  <= tick_cnt_d;
      osc_q       <= osc_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  byte_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .push      (byte_done),
    .push_data (shift_q),
    .pop       (rd_ready),
    .pop_data  (rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rd_valid    = !fifo_empty;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_gps_uart_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_gps_uart_rx : directed self-checking bench, 16 clocks per bit, depth 4.
// ---------------------------------------------------------------------------
module tb_gps_uart_rx;

  logic       clk = 1'b0;
  logic       reset_reset_n = 1'b1;
  logic       rxd = 1'b1;
  logic       rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [2:0] fifo_count;
  logic       frame_err;
  logic       overrun_err;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int rise_cyc = -1;
  logic valid_prev = 1'b0;

  gps_uart_rx #(
    .CLK_HZ     (16_000_000),
    .BAUD       (1_000_000),
    .DATA_BITS  (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (reset_reset_n),
    .rxd           (rxd),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .fifo_count    (fifo_count),
    .frame_err     (frame_err),
    .overrun_err   (overrun_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err)   fe_cnt <= fe_cnt + 1;
    if (overrun_err) ov_cnt <= ov_cnt + 1;
    if (rd_valid && !valid_prev) rise_cyc <= cyc;
    valid_prev <= rd_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one frame, 16 clocks per bit; enters and leaves 1 time unit after a rising edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      repeat (16) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    @(posedge clk);
    #1;
    rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_reset_n = 1'b0;
    #22;
    tests_run++;
    if (rd_valid !== 1'b0 || fifo_count !== 3'd0 || rd_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_outputs: valid=%b count=%0d data=%h, required 0/0/00",
               rd_valid, fifo_count, rd_data);
    end
    tests_run++;
    if (frame_err !== 1'b0 || overrun_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_errors: frame_err=%b overrun_err=%b, required 0/0",
               frame_err, overrun_err);
    end
    @(posedge clk);
    #1;
    reset_reset_n = 1'b1;
    idle(5);
  endtask

  task automatic test_single();
    int start, fe0, ov0;
    start = cyc;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_frame(8'hA5, 1'b1);
    idle(4);
    tests_run++;
    if (rise_cyc !== start + 155) begin
      tests_failed++;
      $display("FAIL single_latency: rd_valid rose at cycle %0d, required %0d", rise_cyc, start + 155);
    end
    tests_run++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || fifo_count !== 3'd1) begin
      tests_failed++;
      $display("FAIL single_data: valid=%b data=%h count=%0d, required 1/a5/1", rd_valid, rd_data, fifo_count);
    end
    tests_run++;
    if (fe_cnt != fe0 || ov_cnt != ov0) begin
      tests_failed++;
      $display("FAIL single_errors: frame_err pulses=%0d overrun pulses=%0d, required 0/0",
               fe_cnt - fe0, ov_cnt - ov0);
    end
    pop_one();
    tests_run++;
    if (rd_valid !== 1'b0 || fifo_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL single_pop: valid=%b count=%0d, required 0/0", rd_valid, fifo_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [4] = '{8'h24, 8'h47, 8'h50, 8'h0D};
    for (int i = 0; i < 4; i++) send_frame(exp[i], 1'b1);
    idle(4);
    tests_run++;
    if (fifo_count !== 3'd4) begin
      tests_failed++;
      $display("FAIL b2b_count: count=%0d, required 4", fifo_count);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (rd_valid !== 1'b1 || rd_data !== exp[i]) begin
        tests_failed++;
        $display("FAIL b2b_order[%0d]: valid=%b data=%h, required 1/%h", i, rd_valid, rd_data, exp[i]);
      end
      pop_one();
    end
    tests_run++;
    if (rd_valid !== 1'b0 || fifo_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL b2b_drained: valid=%b count=%0d, required 0/0", rd_valid, fifo_count);
    end
  endtask

  task automatic test_overrun();
    int ov0;
    send_frame(8'h24, 1'b1);
    send_frame(8'h47, 1'b1);
    send_frame(8'h50, 1'b1);
    send_frame(8'h0D, 1'b1);
    ov0 = ov_cnt;
    send_frame(8'h55, 1'b1);
    idle(4);
    tests_run++;
    if (ov_cnt - ov0 != 1) begin
      tests_failed++;
      $display("FAIL overrun_pulse: overrun high for %0d cycles, required 1", ov_cnt - ov0);
    end
    tests_run++;
    if (fifo_count !== 3'd4 || rd_data !== 8'h24) begin
      tests_failed++;
      $display("FAIL overrun_contents: count=%0d head=%h, required 4/24", fifo_count, rd_data);
    end
  endtask

  task automatic test_pop_on_full();
    int ov0;
    logic [7:0] exp [4] = '{8'h47, 8'h50, 8'h0D, 8'h55};
    ov0 = ov_cnt;
    fork
      send_frame(8'h55, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1;
        rd_ready = 1'b1;
        @(posedge clk);
        #1;
        rd_ready = 1'b0;
      end
    join
    idle(4);
    tests_run++;
    if (fifo_count !== 3'd4 || ov_cnt != ov0) begin
      tests_failed++;
      $display("FAIL pop_on_full: count=%0d overrun pulses=%0d, required 4/0", fifo_count, ov_cnt - ov0);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (rd_valid !== 1'b1 || rd_data !== exp[i]) begin
        tests_failed++;
        $display("FAIL pop_on_full_order[%0d]: valid=%b data=%h, required 1/%h", i, rd_valid, rd_data, exp[i]);
      end
      pop_one();
    end
  endtask

  task automatic test_glitch();
    int fe0, ov0;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    rxd = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    idle(40);
    tests_run++;
    if (fifo_count !== 3'd0 || fe_cnt != fe0 || ov_cnt != ov0) begin
      tests_failed++;
      $display("FAIL glitch_ignored: count=%0d frame pulses=%0d overrun pulses=%0d, required 0/0/0",
               fifo_count, fe_cnt - fe0, ov_cnt - ov0);
    end
    send_frame(8'h3C, 1'b1);
    idle(4);
    tests_run++;
    if (fifo_count !== 3'd1 || rd_data !== 8'h3C) begin
      tests_failed++;
      $display("FAIL glitch_next_frame: count=%0d data=%h, required 1/3c", fifo_count, rd_data);
    end
    pop_one();
  endtask

  task automatic test_frame_error();
    int fe0, ov0;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_frame(8'h81, 1'b0);
    rxd = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    idle(20);
    tests_run++;
    if (fe_cnt - fe0 != 1 || ov_cnt != ov0) begin
      tests_failed++;
      $display("FAIL frame_err_pulse: frame pulses=%0d overrun pulses=%0d, required 1/0",
               fe_cnt - fe0, ov_cnt - ov0);
    end
    tests_run++;
    if (fifo_count !== 3'd0 || rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL frame_err_no_push: count=%0d valid=%b, required 0/0", fifo_count, rd_valid);
    end
    send_frame(8'h12, 1'b1);
    idle(4);
    tests_run++;
    if (fifo_count !== 3'd1 || rd_data !== 8'h12) begin
      tests_failed++;
      $display("FAIL frame_err_recover: count=%0d data=%h, required 1/12", fifo_count, rd_data);
    end
  endtask

  task automatic test_async_reset();
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (40) @(posedge clk);
        #3;
        reset_reset_n = 1'b0;
        #1;
        tests_run++;
        if (rd_valid !== 1'b0 || fifo_count !== 3'd0 || rd_data !== 8'h00) begin
          tests_failed++;
          $display("FAIL async_reset: valid=%b count=%0d data=%h, required 0/0/00",
                   rd_valid, fifo_count, rd_data);
        end
      end
    join
    reset_reset_n = 1'b1;
    idle(20);
    tests_run++;
    if (rd_valid !== 1'b0 || fe_cnt < 0) begin
      tests_failed++;
      $display("FAIL async_reset_after: valid=%b, required 0", rd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_pop_on_full();
    test_glitch();
    test_frame_error();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
